// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined wide adder.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CHUNK = 4;

    // Pipeline depth: one register stage per CHUNK-bit slice of the carry chain.
    function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    function automatic bit chunking_ok(input int unsigned width, input int unsigned chunk);
        return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// Combinational CHUNK-bit ripple slice; also exposes the carry into its MSB for overflow.
module adder_chunk_stage
    import adder_pkg::*;
#(
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < int'(CHUNK); i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[CHUNK];
    assign cmsb = carry[CHUNK-1];

endmodule

// File: rtl/pipelined_nbit_adder.sv
// WIDTH-bit add/subtract with carry/borrow-in, carry chain cut into CHUNK-bit
// register stages, one beat per cycle under valid/ready flow control.
module pipelined_nbit_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             ic,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             oc,
    output logic             ovf
);

    localparam int unsigned     STAGES     = num_stages(WIDTH, CHUNK);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if (!chunking_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("pipelined_nbit_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic             adv;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Per-stage inputs (from ports for stage 0, else from the previous stage registers)
    logic [WIDTH-1:0] st_a     [STAGES];
    logic [WIDTH-1:0] st_b     [STAGES];
    logic             st_cin   [STAGES];
    logic             st_sub   [STAGES];
    logic             st_valid [STAGES];

    logic [CHUNK-1:0] sum_c    [STAGES];
    logic             cout_c   [STAGES];
    logic             cmsb_c   [STAGES];
    logic [WIDTH-1:0] nxt_word [STAGES];

    // Stage registers: word_q holds finished sum chunks below the operand-A chunks still pending
    logic [WIDTH-1:0] word_q   [STAGES];
    logic [WIDTH-1:0] b_q      [STAGES];
    logic             carry_q  [STAGES];
    logic             sub_q    [STAGES];
    logic             valid_q  [STAGES];
    logic             oc_q;
    logic             ovf_q;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;
    assign accept   = in_valid && in_ready;
    assign b_eff    = sub ? ~in2 : in2;
    assign cin_eff  = ic ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign st_a[k]     = in1;
            assign st_b[k]     = b_eff;
            assign st_cin[k]   = cin_eff;
            assign st_sub[k]   = sub;
            assign st_valid[k] = accept;
        end else begin : g_next
            assign st_a[k]     = word_q[k-1];
            assign st_b[k]     = b_q[k-1];
            assign st_cin[k]   = carry_q[k-1];
            assign st_sub[k]   = sub_q[k-1];
            assign st_valid[k] = valid_q[k-1];
        end

        adder_chunk_stage #(.CHUNK(CHUNK)) u_chunk (
            .a    (st_a[k][k*CHUNK +: CHUNK]),
            .b    (st_b[k][k*CHUNK +: CHUNK]),
            .cin  (st_cin[k]),
            .sum  (sum_c[k]),
            .cout (cout_c[k]),
            .cmsb (cmsb_c[k])
        );

        assign nxt_word[k] = (st_a[k] & ~(CHUNK_MASK << (k*CHUNK)))
                           | (WIDTH'(sum_c[k]) << (k*CHUNK));
    end

    // Whole pipeline advances together; bubbles hold in place during a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                word_q[k]  <= '0;
                b_q[k]     <= '0;
                carry_q[k] <= 1'b0;
                sub_q[k]   <= 1'b0;
                valid_q[k] <= 1'b0;
            end
            oc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                word_q[k]  <= nxt_word[k];
                b_q[k]     <= st_b[k];
                carry_q[k] <= cout_c[k];
                sub_q[k]   <= st_sub[k];
                valid_q[k] <= st_valid[k];
            end
            oc_q  <= cout_c[STAGES-1] ^ st_sub[STAGES-1];
            ovf_q <= cmsb_c[STAGES-1] ^ cout_c[STAGES-1];
        end
    end

    assign out       = word_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];
    assign oc        = oc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_nbit_adder.sv
// Self-checking bench for pipelined_nbit_adder (WIDTH=16, CHUNK=4) against an
// arithmetic reference model.
module tb_pipelined_nbit_adder;

    localparam int unsigned W   = 16;
    localparam int          LAT = 4;

    typedef logic [W+1:0] res_t;  // {ovf, oc, out}

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         s;
        logic [W-1:0] o;
        logic         co;
        logic         ov;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         ic;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         oc;
    logic         ovf;

    int   tests = 0;
    int   fails = 0;
    res_t exp_q[$];

    pipelined_nbit_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .ic        (ic),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .oc        (oc),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: true integer arithmetic on the operands
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        int unsigned ua, ub, ci_u, ru;
        int          sa, sb, ci, rs;
        logic        cy, ov;
        ua   = 32'(a);
        ub   = 32'(b);
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        ci   = c ? 1 : 0;
        ci_u = c ? 32'd1 : 32'd0;
        if (!s) begin
            ru = ua + ub + ci_u;
            cy = ru[16];
            rs = sa + sb + ci;
        end else begin
            ru = ua - ub - ci_u;
            cy = (ua < ub + ci_u);
            rs = sa - sb - ci;
        end
        ov = (rs > 32767) || (rs < -32768);
        return {ov, cy, ru[15:0]};
    endfunction

    // One clock: drive after the edge, sample once inputs settle
    task automatic step(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input logic ordy,
                        output logic acc, output logic got);
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in1 = a; in2 = b; ic = c; sub = s; out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        got = out_valid && out_ready;
    endtask

    task automatic test_reset();
        logic acc, got;
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b1, acc, got);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (out !== 16'h0000) begin fails++; $display("FAIL reset_out got=%h exp=0000", out); end
        tests++; if (oc !== 1'b0) begin fails++; $display("FAIL reset_oc got=%b exp=0", oc); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, got);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_directed();
        vec_t v [9] = '{
            '{16'h0002, 16'h0001, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0},
            '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
            '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
            '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
            '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0},
            '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0},
            '{16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b0},
            '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1},
            '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0}
        };
        logic acc, got;
        int   lat;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, v[i].a, v[i].b, v[i].c, v[i].s, 1'b1, acc, got);
            tests++; if (acc !== 1'b1) begin fails++; $display("FAIL dir%0d_accept got=%b exp=1", i, acc); end
            lat = 0;
            for (int n = 1; n <= 20 && lat == 0; n++) begin
                step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, got);
                if (out_valid === 1'b1) lat = n;
            end
            tests++; if (lat != LAT) begin fails++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); end
            tests++; if (out !== v[i].o) begin fails++; $display("FAIL dir%0d_out got=%h exp=%h", i, out, v[i].o); end
            tests++; if (oc !== v[i].co) begin fails++; $display("FAIL dir%0d_oc got=%b exp=%b", i, oc, v[i].co); end
            tests++; if (ovf !== v[i].ov) begin fails++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ovf, v[i].ov); end
        end
    endtask

    // Streams n beats; rand_flow randomizes valid/ready, otherwise back-to-back with a 3-cycle stall
    task automatic test_stream(input int n, input bit rand_flow, input int max_cyc);
        logic [W-1:0] a, b;
        logic         c, s, v, ordy, acc, got, stalled;
        res_t         held, e;
        int           sent, recv, extra;
        exp_q.delete();
        sent = 0; recv = 0; stalled = 1'b0; held = '0;
        a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); s = 1'($urandom);
        for (int cyc = 0; cyc < max_cyc && recv < n; cyc++) begin
            if (rand_flow) begin
                v    = (sent < n) && ($urandom_range(0, 3) != 0);
                ordy = ($urandom_range(0, 2) != 0);
            end else begin
                v    = (sent < n);
                ordy = !(cyc >= 5 && cyc <= 7);
            end
            step(1'b0, v, a, b, c, s, ordy, acc, got);
            if (stalled) begin
                tests++;
                if (out_valid !== 1'b1 || {ovf, oc, out} !== held) begin
                    fails++; $display("FAIL hold_stable got=%b/%h exp=1/%h", out_valid, {ovf, oc, out}, held);
                end
            end
            if (out_valid === 1'b1 && !ordy) begin
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
                held = {ovf, oc, out};
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (acc) begin
                exp_q.push_back(model(a, b, c, s));
                sent++;
                a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); s = 1'($urandom);
            end
            if (got) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL stream_extra_beat got=%h exp=none", {ovf, oc, out});
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf, oc, out} !== e) begin fails++; $display("FAIL stream_beat%0d got=%h exp=%h", recv, {ovf, oc, out}, e); end
                end
                recv++;
            end
        end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, got);
            if (out_valid === 1'b1) extra++;
        end
        tests++;
        if (recv != n || exp_q.size() != 0 || extra != 0) begin
            fails++; $display("FAIL stream_count got=%0d+%0d extra exp=%0d (pending %0d)", recv, extra, n, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic [W-1:0] a, b;
        logic         c, s, acc, got;
        int           ghosts, lat;
        res_t         e;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc, got);
            tests++; if (acc !== 1'b1) begin fails++; $display("FAIL rst_mid_accept%0d got=%b exp=1", i, acc); end
        end
        step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, acc, got);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_in_ready got=%b exp=0", in_ready); end
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, got);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
        ghosts = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, got);
            if (out_valid === 1'b1) ghosts++;
        end
        tests++; if (ghosts != 0) begin fails++; $display("FAIL rst_mid_ghosts got=%0d exp=0", ghosts); end
        a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); s = 1'($urandom);
        e = model(a, b, c, s);
        step(1'b0, 1'b1, a, b, c, s, 1'b1, acc, got);
        tests++; if (acc !== 1'b1) begin fails++; $display("FAIL rst_mid_new_accept got=%b exp=1", acc); end
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, got);
            if (out_valid === 1'b1) lat = n;
        end
        tests++; if (lat != LAT) begin fails++; $display("FAIL rst_mid_new_latency got=%0d exp=%0d", lat, LAT); end
        tests++; if ({ovf, oc, out} !== e) begin fails++; $display("FAIL rst_mid_new_result got=%h exp=%h", {ovf, oc, out}, e); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; ic = 1'b0; sub = 1'b0; out_ready = 1'b1;
        test_reset();
        test_directed();
        test_stream(8, 1'b0, 60);
        test_stream(30, 1'b1, 600);
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
